tick_deserializer: RTL and testbench

Downstream consumer of the tick-counter stage: it samples a serial bit on every `counter_done` tick and assembles `DATA_WIDTH` consecutive samples into a parallel word. Completed words are offered on a valid/ready output with a one-word holding register. Words that cannot be accepted are dropped and recorded in a sticky overrun flag. It sits between the tick/bit producer and any parallel consumer (register bank, FIFO, UART TX).

---
 rtl/tick_deserializer.sv | 54 +++++
 tb/tb_tick_deserializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tick_deserializer.sv
// tick_deserializer: shifts in one bit per sample_tick, MSB-first, and offers each completed
// DATA_WIDTH-bit word through a one-word valid/ready holding register with a sticky overrun flag.
module tick_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          bit_in,
  input  logic                          out_ready,
  input  logic                          clr_overrun,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  output logic                          overrun,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_count
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, data_q, data_d, word;
  logic [CW-1:0]         bit_count_q, bit_count_d;
  logic                  overrun_q, overrun_d, wc, load, drop;
  always_comb begin
    word        = {shreg_q[DATA_WIDTH-2:0], bit_in};
    wc          = sample_tick && bit_count_q == CW'(DATA_WIDTH - 1);
    load        = wc && (state_q == EMPTY || out_ready);
    drop        = wc && !load;
    shreg_d     = sample_tick ? word : shreg_q;
    bit_count_d = wc ? '0 : sample_tick ? bit_count_q + CW'(1) : bit_count_q;
    state_d     = load ? FULL : out_ready ? EMPTY : state_q;
    data_d      = load ? word : data_q;
    // a drop in the same cycle as a clear leaves the flag set
    overrun_d   = drop || (overrun_q && !clr_overrun);
  end
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      shreg_q     <= '0;
      data_q      <= '0;
      bit_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      bit_count_q <= bit_count_d;
      overrun_q   <= overrun_d;
    end
  end
  assign out_data  = data_q;
  assign out_valid = state_q == FULL;
  assign overrun   = overrun_q;
  assign bit_count = bit_count_q;
endmodule

// File: tb/tb_tick_deserializer.sv
// tb_tick_deserializer: three widths (8, 2, 32) share one stimulus stream; a tick-history model
// predicts every output each cycle, with literal expectations pinning the directed scenarios.
module tb_tick_deserializer;
  logic sys_clk = 0, rst = 1, sample_tick = 0, bit_in = 0, out_ready = 0, clr_overrun = 0;
  always #5 sys_clk = ~sys_clk;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [31:0] d32;
  logic [2:0]  bc8;
  logic [0:0]  bc2;
  logic [4:0]  bc32;
  logic [2:0]  v, o;
  tick_deserializer #(.DATA_WIDTH(8)) u8 (.sys_clk(sys_clk), .rst(rst), .sample_tick(sample_tick),
    .bit_in(bit_in), .out_ready(out_ready), .clr_overrun(clr_overrun), .out_data(d8),
    .out_valid(v[0]), .overrun(o[0]), .bit_count(bc8));
  tick_deserializer #(.DATA_WIDTH(2)) u2 (.sys_clk(sys_clk), .rst(rst), .sample_tick(sample_tick),
    .bit_in(bit_in), .out_ready(out_ready), .clr_overrun(clr_overrun), .out_data(d2),
    .out_valid(v[1]), .overrun(o[1]), .bit_count(bc2));
  tick_deserializer #(.DATA_WIDTH(32)) u32 (.sys_clk(sys_clk), .rst(rst), .sample_tick(sample_tick),
    .bit_in(bit_in), .out_ready(out_ready), .clr_overrun(clr_overrun), .out_data(d32),
    .out_valid(v[2]), .overrun(o[2]), .bit_count(bc32));

  int checks = 0, errors = 0;
  int ticks[3], comps[3], drops[3], acc[3];
  logic [31:0] mdata[3];
  bit mvalid[3], movr[3];
  bit hist[$];

  function automatic int wid(int k);
    return k == 0 ? 8 : k == 1 ? 2 : 32;
  endfunction
  function automatic logic [31:0] got_data(int k);
    return k == 0 ? 32'(d8) : k == 1 ? 32'(d2) : d32;
  endfunction
  function automatic logic [31:0] got_bc(int k);
    return k == 0 ? 32'(bc8) : k == 1 ? 32'(bc2) : 32'(bc32);
  endfunction
  // the last w sampled bits, oldest in the MSB
  function automatic logic [31:0] window(int w);
    logic [31:0] r = 0;
    for (int i = 0; i < w; i++) r = (r << 1) | 32'(hist[hist.size() - w + i]);
    return r;
  endfunction

  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (width %0d) @%0t: got %0h, expected %0h", name, wid(k), $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ticks[k] = 0; comps[k] = 0; drops[k] = 0; acc[k] = 0;
      mdata[k] = 0; mvalid[k] = 0; movr[k] = 0;
    end
    hist.delete();
  endtask

  task automatic model_edge();
    bit comp, drop;
    if (rst) begin
      model_reset();
      return;
    end
    if (sample_tick) begin
      hist.push_back(bit_in);
      if (hist.size() > 32) void'(hist.pop_front());
    end
    for (int k = 0; k < 3; k++) begin
      comp = sample_tick && ((ticks[k] + 1) % wid(k) == 0);
      if (sample_tick) ticks[k]++;
      drop = comp && mvalid[k] && !out_ready;
      if (comp) comps[k]++;
      if (drop) drops[k]++;
      if (comp && !drop) begin
        mdata[k] = window(wid(k));
        mvalid[k] = 1;
      end else if (mvalid[k] && out_ready) mvalid[k] = 0;
      movr[k] = drop || (movr[k] && !clr_overrun);
    end
  endtask

  task automatic step();
    for (int k = 0; k < 3; k++) if (v[k] && out_ready && !rst) acc[k]++;
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    for (int k = 0; k < 3; k++) begin
      chk("out_data", k, got_data(k), mdata[k]);
      chk("out_valid", k, 32'(v[k]), 32'(mvalid[k]));
      chk("overrun", k, 32'(o[k]), 32'(movr[k]));
      chk("bit_count", k, got_bc(k), 32'(ticks[k] % wid(k)));
    end
  endtask

  task automatic drive(logic t, logic b, logic r, logic c);
    sample_tick = t; bit_in = b; out_ready = r; clr_overrun = c;
    step();
  endtask

  // n bits of w, MSB first, with gap idle cycles (random bit_in) between ticks
  task automatic send(logic [31:0] w, int n, int gap, logic r);
    for (int i = n - 1; i >= 0; i--) begin
      if (i != n - 1) repeat (gap) drive(0, 1'($urandom), r, 0);
      drive(1, w[i], r, 0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) step();
    for (int k = 0; k < 3; k++) begin
      chk("reset_data", k, got_data(k), 0);
      chk("reset_valid", k, 32'(v[k]), 0);
    end
    rst = 0;
    send(32'hB2, 8, 4, 1);
    chk("single_data", 0, 32'(d8), 32'hB2);
    chk("single_valid", 0, 32'(v[0]), 1);
    chk("single_bc", 0, 32'(bc8), 0);
    drive(0, 0, 1, 0);
    chk("single_valid_drop", 0, 32'(v[0]), 0);
    send(32'hA5, 8, 0, 1);
    chk("b2b_first", 0, 32'(d8), 32'hA5);
    send(32'h3C, 8, 0, 1);
    chk("b2b_second", 0, 32'(d8), 32'h3C);
    chk("b2b_overrun", 0, 32'(o[0]), 0);
    drive(0, 0, 1, 0);
    send(32'h11, 8, 0, 0);
    chk("ovr_first", 0, 32'(d8), 32'h11);
    send(32'h22, 8, 0, 0);
    chk("ovr_hold", 0, 32'(d8), 32'h11);
    chk("ovr_flag", 0, 32'(o[0]), 1);
    drive(0, 0, 1, 0);
    chk("ovr_consumed", 0, 32'(v[0]), 0);
    drive(0, 0, 0, 0);
    chk("ovr_no_second", 0, 32'(v[0]), 0);
    chk("ovr_data_kept", 0, 32'(d8), 32'h11);
    drive(0, 0, 0, 1);
    chk("clr", 0, 32'(o[0]), 0);
    send(32'h33, 8, 0, 0);
    send(32'h22, 7, 0, 0);
    drive(1, 0, 0, 1);
    chk("clr_set_wins", 0, 32'(o[0]), 1);
    chk("clr_set_data", 0, 32'(d8), 32'h33);
    send(32'h1F, 5, 0, 0);
    rst = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_data", k, got_data(k), 0);
      chk("async_valid", k, 32'(v[k]), 0);
      chk("async_overrun", k, 32'(o[k]), 0);
      chk("async_bc", k, got_bc(k), 0);
    end
    model_reset();
    step();
    rst = 0;
    send(32'hFF, 8, 0, 0);
    chk("post_reset_word", 0, 32'(d8), 32'hFF);
    chk("post_reset_valid", 0, 32'(v[0]), 1);
    for (int i = 0; i < 4000; i++) begin
      int rp, tp;
      rp = (i / 500) % 4 == 0 ? 0 : (i / 500) % 4 == 1 ? 30 : (i / 500) % 4 == 2 ? 70 : 100;
      tp = (i / 250) % 2 == 0 ? 50 : 100;
      drive(1'($urandom_range(99) < tp), 1'($urandom), 1'($urandom_range(99) < rp),
            1'($urandom_range(49) == 0));
    end
    for (int k = 0; k < 3; k++)
      chk("accounting", k, 32'(acc[k] + drops[k] + int'(mvalid[k])), 32'(comps[k]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
